// File: rtl/seq_pattern_gen.sv
// Programmable test-pattern sequencer for the IO-tile pads: binary up/down, Gray or
// Galois LFSR sequence with prescaler, wrap/saturate, parallel load and strobes.
module seq_pattern_gen #(
   parameter int unsigned      WIDTH      = 16,
   parameter int unsigned      PRESCALE_W = 8,
   parameter logic [WIDTH-1:0] LFSR_TAPS  = 16'hB400
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic                  saturate,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      count_o,
   output logic                  tc_o,
   output logic                  step_o
);

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_GRAY = 2'b10,
      MODE_LFSR = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0]      ONE     = WIDTH'(1);
   localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

   logic [WIDTH-1:0]      q;
   logic [PRESCALE_W-1:0] pre_cnt;
   logic                  tick;
   logic                  at_limit;
   logic                  hold;
   logic [WIDTH-1:0]      q_adv;
   logic [WIDTH-1:0]      q_next;
   logic [WIDTH-1:0]      cnt_next;
   mode_e                 mode_s;

   assign mode_s = mode_e'(mode);

   // >= rather than == so a prescale lowered mid-count fires on the next enabled cycle
   assign tick = en && (pre_cnt >= prescale);

   always_comb begin
      q_adv    = q;
      at_limit = 1'b0;
      unique case (mode_s)
         MODE_UP, MODE_GRAY: begin
            q_adv    = q + ONE;
            at_limit = &q;
         end
         MODE_DOWN: begin
            q_adv    = q - ONE;
            at_limit = (q == '0);
         end
         MODE_LFSR: begin
            // all-zero is the Galois lockup state; kick it to 1
            if (q == '0)
               q_adv = ONE;
            else if (q[0])
               q_adv = (q >> 1) ^ LFSR_TAPS;
            else
               q_adv = q >> 1;
            at_limit = (q == ONE);
         end
         default: ;
      endcase
   end

   assign hold = saturate && at_limit && (mode_s != MODE_LFSR);

   always_comb begin
      q_next = q;
      if (load)
         q_next = load_val;
      else if (tick && !hold)
         q_next = q_adv;
   end

   // encoding follows the current mode, so a mode change re-encodes without touching q
   assign cnt_next = (mode_s == MODE_GRAY) ? (q_next ^ (q_next >> 1)) : q_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q       <= '0;
         pre_cnt <= '0;
         count_o <= '0;
         tc_o    <= 1'b0;
         step_o  <= 1'b0;
      end else begin
         q       <= q_next;
         count_o <= cnt_next;
         if (load) begin
            pre_cnt <= '0;
            tc_o    <= 1'b0;
            step_o  <= 1'b0;
         end else if (tick) begin
            pre_cnt <= '0;
            tc_o    <= at_limit;
            step_o  <= 1'b1;
         end else begin
            if (en)
               pre_cnt <= pre_cnt + PRE_ONE;
            tc_o   <= 1'b0;
            step_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: integer reference model checked every cycle,
// plus literal expectations from hand-worked sequences.
module tb_seq_pattern_gen;

   localparam int TAPS = 'hB400;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  mode;
   logic        saturate;
   logic        load;
   logic [15:0] load_val;
   logic [7:0]  prescale;
   logic [15:0] count_o;
   logic        tc_o;
   logic        step_o;

   int n_vec = 0;
   int n_err = 0;

   seq_pattern_gen #(.WIDTH(16), .PRESCALE_W(8), .LFSR_TAPS(16'hB400)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .saturate(saturate),
      .load(load), .load_val(load_val), .prescale(prescale),
      .count_o(count_o), .tc_o(tc_o), .step_o(step_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // one clock: inputs change only at posedge+2, outputs read there too
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Reference model: sequence value as a plain integer, prescaler as a counter.
   int mq, mpre, mcnt, mtc, mstep, nq;
   bit mok = 0, lim, tk;
   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         mq = 0; mpre = 0; mcnt = 0; mtc = 0; mstep = 0; mok = 1;
      end else if (mok) begin
         tk = en && (mpre >= int'(prescale));
         if (load) begin
            mq = int'(load_val); mpre = 0; mtc = 0; mstep = 0;
         end else if (tk) begin
            mpre = 0; mstep = 1;
            case (mode)
               2'd1:    begin lim = (mq == 0);     nq = (mq + 65535) % 65536; end
               2'd3:    begin
                  lim = (mq == 1);
                  if (mq == 0) nq = 1;
                  else if (mq % 2 == 1) nq = (mq / 2) ^ TAPS;
                  else nq = mq / 2;
               end
               default: begin lim = (mq == 65535); nq = (mq + 1) % 65536; end
            endcase
            mtc = lim ? 1 : 0;
            if (!(lim && saturate && mode != 2'd3)) mq = nq;
         end else begin
            if (en) mpre = (mpre + 1) % 256;
            mtc = 0; mstep = 0;
         end
         mcnt = (mode == 2'd2) ? (mq ^ (mq / 2)) : mq;
      end
      #1;
      if (mok) begin
         chk("model_count", int'(count_o), mcnt);
         chk("model_tc", int'(tc_o), mtc);
         chk("model_step", int'(step_o), mstep);
      end
   end

   initial begin
      int steps, first, last, gap_ok, found;
      rst_n = 0; en = 0; mode = 0; saturate = 0; load = 0; load_val = 0; prescale = 0;
      cyc();
      chk("rst_count", int'(count_o), 0);
      chk("rst_tc", int'(tc_o), 0);
      chk("rst_step", int'(step_o), 0);

      // binary up, step every cycle
      rst_n = 1; en = 1;
      cyc(); chk("up_1", int'(count_o), 1);
      cyc(); chk("up_2", int'(count_o), 2);
      cyc(); chk("up_3", int'(count_o), 3);
      load = 1; load_val = 16'hFFFF;
      cyc(); chk("load_ffff", int'(count_o), 'hFFFF); chk("load_tc", int'(tc_o), 0);
      load = 0;
      cyc(); chk("wrap_count", int'(count_o), 0); chk("wrap_tc", int'(tc_o), 1);
      cyc(); chk("wrap_tc_off", int'(tc_o), 0);

      // prescale 3 over 12 cycles
      load = 1; load_val = 0; prescale = 3;
      cyc();
      load = 0;
      steps = 0; first = 0; last = 0; gap_ok = 1;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         if (step_o) begin
            if (steps > 0 && i - last != 4) gap_ok = 0;
            if (steps == 0) first = i;
            last = i; steps++;
         end
      end
      chk("pre_steps", steps, 3);
      chk("pre_gap4", gap_ok, 1);
      chk("pre_first", first, 4);
      chk("pre_count", int'(count_o), 3);

      // en dropped for 5 cycles stretches interval to 9
      found = 0;
      for (int i = 1; i <= 20; i++) begin
         en = !(i >= 3 && i <= 7);
         cyc();
         if (step_o && found == 0) found = i;
      end
      chk("en_gap9", found, 9);
      en = 1;

      // down, saturate at 0
      mode = 2'd1; saturate = 1; prescale = 0; load = 1; load_val = 2;
      cyc();
      load = 0;
      cyc(); chk("sat_c1", int'(count_o), 1); chk("sat_tc1", int'(tc_o), 0);
      cyc(); chk("sat_c2", int'(count_o), 0); chk("sat_tc2", int'(tc_o), 0);
      cyc(); chk("sat_c3", int'(count_o), 0); chk("sat_tc3", int'(tc_o), 1);
      cyc(); chk("sat_c4", int'(count_o), 0); chk("sat_tc4", int'(tc_o), 1);

      // Gray, then re-encode as binary while frozen
      mode = 2'd2; saturate = 0; load = 1; load_val = 16'h0007;
      cyc(); chk("gray_load", int'(count_o), 'h0004);
      load = 0;
      cyc(); chk("gray_8", int'(count_o), 'h000C);
      mode = 2'd0; en = 0;
      cyc(); chk("reenc_8", int'(count_o), 'h0008);

      // LFSR from lockup state
      mode = 2'd3; en = 1; load = 1; load_val = 0;
      cyc();
      load = 0;
      cyc(); chk("lfsr_1", int'(count_o), 'h0001); chk("lfsr_tc1", int'(tc_o), 0);
      cyc(); chk("lfsr_b400", int'(count_o), 'hB400); chk("lfsr_tc2", int'(tc_o), 1);
      cyc(); chk("lfsr_5a00", int'(count_o), 'h5A00); chk("lfsr_tc3", int'(tc_o), 0);

      // reset beats load mid-count, then full prescale interval
      mode = 2'd0; prescale = 2; load = 1; load_val = 5;
      cyc();
      load = 0;
      cyc();
      rst_n = 0; load = 1; load_val = 16'h1234;
      cyc();
      chk("rst2_count", int'(count_o), 0);
      chk("rst2_tc", int'(tc_o), 0);
      chk("rst2_step", int'(step_o), 0);
      rst_n = 1; load = 0;
      found = 0;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (step_o && found == 0) begin
            found = i;
            chk("rst2_first_cnt", int'(count_o), 1);
         end
      end
      chk("rst2_first_step", found, 3);

      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
